// File: rtl/msu_ctrl_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : msu_ctrl_prefetch
// Desc     : MSU-1 register front end ($2000-$2007, banks $00-$3F/$80-$BF)
//            with a FIFO_DEPTH-byte data prefetch buffer refilled over a
//            req/ack fetch port, plus audio track/volume/control registers
//            and resume-point capture.
// Options  : define MSU_VOLUME_FADE_EN to ramp volume one step toward the
//            $2006 target every FADE_DIV SYSCLKF_CE pulses.
// Revision : 1.0 - initial release
// ============================================================================
module msu_ctrl_prefetch #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32,
  parameter int FADE_DIV   = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic              RD_N,
  input  logic              WR_N,
  input  logic              SYSCLKF_CE,
  input  logic [23:0]       ADDR,
  input  logic [7:0]        DIN,
  output logic [7:0]        DOUT,
  output logic              MSU_SEL,
  output logic [15:0]       track_num,
  output logic              track_request,
  input  logic              track_mounting,
  output logic [7:0]        volume,
  input  logic              status_track_missing,
  output logic              status_audio_repeat,
  output logic              status_audio_playing,
  input  logic              audio_stop,
  output logic              audio_resume,
  input  logic [21:0]       audio_sector,
  output logic [21:0]       resume_sector,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_req,
  input  logic [7:0]        fetch_data,
  input  logic              fetch_ack
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [31:0]        seek_q, seek_d;
  logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
  logic [7:0]         fifo_q [FIFO_DEPTH];
  logic [7:0]         fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               rd_sel_q;
  logic               mounting_q;
  logic [7:0]         track_lsb_q, track_lsb_d;
  logic [15:0]        track_num_q, track_num_d;
  logic               track_request_q, track_request_d;
  logic [7:0]         volume_q, volume_d;
  logic               repeat_q, repeat_d, playing_q, playing_d;
  logic               resume_valid_q, resume_valid_d;
  logic [15:0]        resume_track_q, resume_track_d;
  logic [21:0]        resume_sector_q, resume_sector_d;
  logic               audio_resume_q, audio_resume_d;
  logic [7:0]         dout_q, dout_d;

  logic wr_en, rd_sel, seek_wr, push, pop, fifo_empty, fifo_full;
  logic [7:0] fifo_head, status;
  logic unused_addr;

  assign MSU_SEL     = ENABLE & ~ADDR[22] & (ADDR[15:3] == 13'h0400);
  assign wr_en       = MSU_SEL & SYSCLKF_CE & ~WR_N;
  assign rd_sel      = MSU_SEL & ~RD_N & (ADDR[2:0] == 3'd1);
  assign seek_wr     = wr_en & (ADDR[2:0] == 3'd3);
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == FULL_CNT);
  assign fifo_head   = fifo_q[rd_ptr_q];
  assign status      = {busy_q, track_request_q, repeat_q, playing_q, status_track_missing, 3'b010};
  assign unused_addr = ^{ADDR[23], ADDR[21:16]};

  // Seek register, fetch FSM and prefetch FIFO bookkeeping.
  always_comb begin
    state_d      = state_q;
    seek_d       = seek_q;
    fetch_addr_d = fetch_addr_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    busy_d       = busy_q;
    push         = 1'b0;
    // A pop completes when the $2001 read strobe is released.
    pop          = rd_sel_q & ~rd_sel & ~busy_q & ~fifo_empty & ~seek_wr;

    if (wr_en) begin
      case (ADDR[2:0])
        3'd0:    seek_d[7:0]   = DIN;
        3'd1:    seek_d[15:8]  = DIN;
        3'd2:    seek_d[23:16] = DIN;
        3'd3:    seek_d[31:24] = DIN;
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (!seek_wr && !fifo_full) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // An ack coinciding with a seek carries stale data: drop it.
        if (fetch_ack) begin
          state_d = ST_IDLE;
          push    = ~seek_wr & ~fifo_full;
        end else if (seek_wr) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fetch_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (seek_wr) begin
      fetch_addr_d = ADDR_W'({DIN, seek_q[23:0]});
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      busy_d       = 1'b1;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = fetch_data;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        fetch_addr_d     = fetch_addr_q + ADDR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (busy_q && (count_d == FULL_CNT)) busy_d = 1'b0;
    end
  end

  // Audio control registers, resume capture and registered read mux.
  always_comb begin
    track_lsb_d     = track_lsb_q;
    track_num_d     = track_num_q;
    track_request_d = track_request_q;
    repeat_d        = repeat_q;
    playing_d       = playing_q;
    resume_valid_d  = resume_valid_q;
    resume_track_d  = resume_track_q;
    resume_sector_d = resume_sector_q;
    audio_resume_d  = 1'b0;
    dout_d          = 8'h00;

    if (mounting_q && !track_mounting) track_request_d = 1'b0;
    if (audio_stop) playing_d = 1'b0;

    if (wr_en) begin
      case (ADDR[2:0])
        3'd4: track_lsb_d = DIN;
        3'd5: begin
          track_num_d     = {DIN, track_lsb_q};
          track_request_d = 1'b1;
          if (resume_valid_q && (resume_track_q == {DIN, track_lsb_q})) begin
            audio_resume_d = 1'b1;
            resume_valid_d = 1'b0;
          end
        end
        3'd7: begin
          repeat_d  = DIN[1];
          playing_d = DIN[0];
          if (DIN[2] && !DIN[0]) begin
            resume_track_d  = track_num_q;
            resume_sector_d = audio_sector;
            resume_valid_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    case (ADDR[2:0])
      3'd0:    dout_d = status;
      3'd1:    dout_d = fifo_empty ? 8'h00 : fifo_head;
      3'd2:    dout_d = 8'h53;
      3'd3:    dout_d = 8'h2D;
      3'd4:    dout_d = 8'h4D;
      3'd5:    dout_d = 8'h53;
      3'd6:    dout_d = 8'h55;
      default: dout_d = 8'h31;
    endcase
  end

`ifdef MSU_VOLUME_FADE_EN
  localparam int DIV_W = $clog2(FADE_DIV + 1);
  logic [7:0]       target_q, target_d;
  logic [DIV_W-1:0] div_q, div_d;

  // Step volume toward the target once every FADE_DIV CE pulses.
  always_comb begin
    target_d = target_q;
    div_d    = div_q;
    volume_d = volume_q;
    if (wr_en && (ADDR[2:0] == 3'd6)) begin
      target_d = DIN;
      div_d    = '0;
    end else if (SYSCLKF_CE && (volume_q != target_q)) begin
      if (div_q == DIV_W'(FADE_DIV - 1)) begin
        div_d    = '0;
        volume_d = (volume_q < target_q) ? volume_q + 8'd1 : volume_q - 8'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Fade target and divider registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      target_q <= '0;
      div_q    <= '0;
    end else begin
      target_q <= target_d;
      div_q    <= div_d;
    end
  end
`else
  // Volume takes the written value directly.
  always_comb begin
    volume_d = volume_q;
    if (wr_en && (ADDR[2:0] == 3'd6)) volume_d = DIN;
  end

  // FADE_DIV has no role without the fade ramp; keep a range marker only.
  if (FADE_DIV < 1) begin : g_fade_div_range
  end
`endif

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= ST_IDLE;
      seek_q          <= '0;
      fetch_addr_q    <= '0;
      fifo_q          <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      busy_q          <= 1'b0;
      rd_sel_q        <= 1'b0;
      mounting_q      <= 1'b0;
      track_lsb_q     <= '0;
      track_num_q     <= '0;
      track_request_q <= 1'b0;
      volume_q        <= '0;
      repeat_q        <= 1'b0;
      playing_q       <= 1'b0;
      resume_valid_q  <= 1'b0;
      resume_track_q  <= '0;
      resume_sector_q <= '0;
      audio_resume_q  <= 1'b0;
      dout_q          <= '0;
    end else begin
      state_q         <= state_d;
      seek_q          <= seek_d;
      fetch_addr_q    <= fetch_addr_d;
      fifo_q          <= fifo_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      rd_sel_q        <= rd_sel;
      mounting_q      <= track_mounting;
      track_lsb_q     <= track_lsb_d;
      track_num_q     <= track_num_d;
      track_request_q <= track_request_d;
      volume_q        <= volume_d;
      repeat_q        <= repeat_d;
      playing_q       <= playing_d;
      resume_valid_q  <= resume_valid_d;
      resume_track_q  <= resume_track_d;
      resume_sector_q <= resume_sector_d;
      audio_resume_q  <= audio_resume_d;
      dout_q          <= dout_d;
    end
  end

  assign DOUT                 = dout_q;
  assign track_num            = track_num_q;
  assign track_request        = track_request_q;
  assign volume               = volume_q;
  assign status_audio_repeat  = repeat_q;
  assign status_audio_playing = playing_q;
  assign audio_resume         = audio_resume_q;
  assign resume_sector        = resume_sector_q;
  assign fetch_addr           = fetch_addr_q;
  assign fetch_req            = (state_q == ST_FETCH);

endmodule
`default_nettype wire
